// File: rtl/spi_slave_mode.sv
// SPI slave with selectable CPOL/CPHA, bit order and word length, sampled into clk.
// A one-word TX holding register feeds the shift register; RX overrun and TX underrun are flagged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs_n high (synchronised); miso forced 0, counters cleared
// LOAD  | one clk after cs_n falls; CPHA=0 preloads the TX shift reg
// SHIFT | frame active; sample/shift on synchronised sclk edges
module spi_slave_mode #(
   parameter int                  DATA_LEN    = 8,
   parameter int                  CPOL        = 0,
   parameter int                  CPHA        = 0,
   parameter int                  MSB_FIRST   = 1,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [DATA_LEN-1:0] IDLE_WORD   = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_LEN-1:0] tx_tdata,
   input  logic                tx_tvalid,
   output logic                tx_tready,
   output logic [DATA_LEN-1:0] rx_tdata,
   output logic                rx_tvalid,
   input  logic                rx_tready,
   output logic                rx_overrun,
   output logic                tx_underrun,
   output logic                busy,
   input  logic                spi_sclk,
   input  logic                spi_mosi,
   input  logic                spi_cs_n,
   output logic                spi_miso
);

   localparam int            CNT_W     = $clog2(DATA_LEN + 1);
   localparam logic          SCLK_IDLE = (CPOL != 0);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_s, sclk_q, mosi_s, cs_s;
   logic                   lead_edge, trail_edge, sample_edge, shift_edge;
   logic                   do_load, do_shift, do_sample, word_done;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_LEN-1:0]    tx_shift, rx_shift, rx_next, hold_reg;
   logic                   hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
         mosi_sync <= '0;
         cs_sync   <= '1;
         sclk_q    <= SCLK_IDLE;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_q    <= sclk_s;
      end
   end

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign lead_edge   = (sclk_q == SCLK_IDLE) && (sclk_s != SCLK_IDLE);
   assign trail_edge  = (sclk_q != SCLK_IDLE) && (sclk_s == SCLK_IDLE);
   assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
   assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_shift  = 1'b0;
      do_sample = 1'b0;
      if (cs_s) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_LOAD;
            ST_LOAD: begin
               state_nxt = ST_SHIFT;
               do_load   = (CPHA == 0);
            end
            ST_SHIFT: begin
               do_sample = sample_edge;
               if (shift_edge) begin
                  if (bit_cnt == '0) do_load  = 1'b1;
                  else               do_shift = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign word_done = do_sample && (bit_cnt == LAST_BIT);
   assign rx_next   = (MSB_FIRST != 0) ? {rx_shift[DATA_LEN-2:0], mosi_s}
                                       : {mosi_s, rx_shift[DATA_LEN-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         tx_underrun <= 1'b0;
      end else begin
         tx_underrun <= 1'b0;
         if (cs_s) begin
            // deselect drops any partial word in both directions
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
         end else begin
            if (do_sample) begin
               rx_shift <= rx_next;
               bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (do_load) begin
               tx_shift    <= hold_full ? hold_reg : IDLE_WORD;
               tx_underrun <= !hold_full;
            end else if (do_shift) begin
               tx_shift <= (MSB_FIRST != 0) ? (tx_shift << 1) : (tx_shift >> 1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
      end else if (do_load && hold_full) begin
         hold_full <= 1'b0;
      end else if (tx_tvalid && !hold_full) begin
         hold_reg  <= tx_tdata;
         hold_full <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_tdata   <= '0;
         rx_tvalid  <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (word_done) begin
            if (!rx_tvalid || rx_tready) begin
               rx_tdata  <= rx_next;
               rx_tvalid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_tvalid && rx_tready) begin
            rx_tvalid <= 1'b0;
         end
      end
   end

   assign tx_tready = !hold_full;
   assign busy      = (state != ST_IDLE);
   assign spi_miso  = (state == ST_IDLE) ? 1'b0
                    : ((MSB_FIRST != 0) ? tx_shift[DATA_LEN-1] : tx_shift[0]);

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: four instances (modes 0,3,1,2) driven by a behavioural SPI master.
// Expected words come from a table and from a word-stream model of TX consumption.
module tb_spi_slave_mode;

   localparam int         HALF   = 8;
   localparam logic [3:0] CPOL_V = 4'b1010;
   localparam logic [3:0] CPHA_V = 4'b0110;
   localparam logic [3:0] MSB_V  = 4'b0111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_tdata [4];
   logic       tx_tvalid [4];
   logic       tx_tready [4];
   logic [7:0] rx_tdata [4];
   logic       rx_tvalid [4];
   logic       rx_tready [4];
   logic       rx_overrun [4];
   logic       tx_underrun [4];
   logic       busy [4];
   logic       sclk [4];
   logic       mosi [4];
   logic       cs_n [4];
   logic       miso [4];

   int checks = 0;
   int errors = 0;

   logic [7:0] fq [4][$];
   logic [7:0] mq [4][$];
   logic [7:0] rxq [4][$];
   int         fptr [4] = '{0, 0, 0, 0};
   int         und [4] = '{0, 0, 0, 0};
   int         ovr [4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_mode #(
         .DATA_LEN   (8),
         .CPOL       (int'(CPOL_V[g])),
         .CPHA       (int'(CPHA_V[g])),
         .MSB_FIRST  (int'(MSB_V[g])),
         .SYNC_STAGES(2),
         .IDLE_WORD  ((g == 2) ? 8'hFF : 8'h00)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .tx_tdata   (tx_tdata[g]),
         .tx_tvalid  (tx_tvalid[g]),
         .tx_tready  (tx_tready[g]),
         .rx_tdata   (rx_tdata[g]),
         .rx_tvalid  (rx_tvalid[g]),
         .rx_tready  (rx_tready[g]),
         .rx_overrun (rx_overrun[g]),
         .tx_underrun(tx_underrun[g]),
         .busy       (busy[g]),
         .spi_sclk   (sclk[g]),
         .spi_mosi   (mosi[g]),
         .spi_cs_n   (cs_n[g]),
         .spi_miso   (miso[g])
      );
   end

   // TX producer: presents queued words, advances when the DUT will accept at the next posedge
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (fptr[k] < fq[k].size()) begin
            tx_tdata[k]  = fq[k][fptr[k]];
            tx_tvalid[k] = 1'b1;
            if (tx_tready[k] && rst_n) fptr[k]++;
         end else begin
            tx_tdata[k]  = 8'h00;
            tx_tvalid[k] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst_n) begin
            if (rx_tvalid[k] && rx_tready[k]) rxq[k].push_back(rx_tdata[k]);
            if (rx_overrun[k])  ovr[k]++;
            if (tx_underrun[k]) und[k]++;
         end
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] idle_of(input int k);
      return (k == 2) ? 8'hFF : 8'h00;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_tx(input int k, input logic [7:0] w);
      fq[k].push_back(w);
      mq[k].push_back(w);
   endtask

   // Words consumed per frame: CPHA=0 loads at LOAD and after every completed word,
   // CPHA=1 loads at the first shift edge of every started word.
   task automatic model_frame(input int k, input int nbits, output logic [7:0] em[4], output int eu);
      int c;
      logic [7:0] w;
      c  = CPHA_V[k] ? (nbits + 7) / 8 : 1 + nbits / 8;
      eu = 0;
      for (int i = 0; i < 4; i++) em[i] = idle_of(k);
      for (int i = 0; i < c; i++) begin
         if (mq[k].size() > 0) w = mq[k].pop_front();
         else begin
            w = idle_of(k);
            eu++;
         end
         if (i < 4) em[i] = w;
      end
   endtask

   task automatic xfer(input int k, input int nbits, input logic [7:0] mw[4], input bit end_cs,
                       output logic [7:0] got[4]);
      logic cpol, cpha;
      int   bp;
      cpol = CPOL_V[k];
      cpha = CPHA_V[k];
      for (int j = 0; j < 4; j++) got[j] = 8'h00;
      cs_n[k] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bp = MSB_V[k] ? 7 - (i % 8) : i % 8;
         if (!cpha) begin
            mosi[k] = mw[i/8][bp];
            tick(HALF);
            if (i == 0) chk("busy_in_frame", 32'(busy[k]), 1);
            sclk[k] = ~cpol;
            got[i/8][bp] = miso[k];
            tick(HALF);
            sclk[k] = cpol;
         end else begin
            tick(HALF);
            if (i == 0) chk("busy_in_frame", 32'(busy[k]), 1);
            sclk[k] = ~cpol;
            mosi[k] = mw[i/8][bp];
            tick(HALF);
            sclk[k] = cpol;
            got[i/8][bp] = miso[k];
         end
      end
      tick(HALF);
      if (end_cs) begin
         cs_n[k] = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic run_frame(input int k, input int nw, input logic [7:0] mw[4], input bit use_tbl,
                            input logic [7:0] tm[4], input int tu);
      logic [7:0] em [4];
      logic [7:0] got [4];
      int eu, r0, u0, o0;
      model_frame(k, nw * 8, em, eu);
      if (use_tbl) begin
         em = tm;
         eu = tu;
      end
      r0 = rxq[k].size();
      u0 = und[k];
      o0 = ovr[k];
      xfer(k, nw * 8, mw, 1'b1, got);
      tick(4);
      for (int i = 0; i < nw; i++) chk($sformatf("miso_word%0d_inst%0d", i, k), 32'(got[i]), 32'(em[i]));
      chk("rx_count", 32'(rxq[k].size() - r0), 32'(nw));
      for (int i = 0; i < nw; i++)
         if (r0 + i < rxq[k].size()) chk($sformatf("rx_word%0d_inst%0d", i, k), 32'(rxq[k][r0+i]), 32'(mw[i]));
      chk("underrun_count", 32'(und[k] - u0), 32'(eu));
      chk("overrun_count", 32'(ovr[k] - o0), 0);
      chk("busy_after", 32'(busy[k]), 0);
   endtask

   typedef struct {
      int          k;
      int          ntx;
      logic [15:0] tx;
      int          nw;
      logic [15:0] mo;
      logic [15:0] em;
      int          eu;
   } vec_t;

   initial begin
      vec_t       tbl [5];
      logic [7:0] mw [4];
      logic [7:0] tm [4];
      logic [7:0] got [4];
      logic [7:0] em [4];
      int         eu, r0, o0, u0, k, nw, ntx;

      // word i of a field is bits [15-8i -: 8]
      tbl[0] = '{0, 1, 16'hA500, 1, 16'h3C00, 16'hA500, 1};
      tbl[1] = '{1, 2, 16'h1234, 2, 16'hF00F, 16'h1234, 0};
      tbl[2] = '{2, 0, 16'h0000, 2, 16'hC35A, 16'hFFFF, 2};
      tbl[3] = '{3, 1, 16'h9600, 1, 16'hE100, 16'h9600, 1};
      tbl[4] = '{0, 2, 16'h1122, 1, 16'h7E00, 16'h1100, 0};

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cs_n[i]      = 1'b1;
         sclk[i]      = CPOL_V[i];
         mosi[i]      = 1'b0;
         rx_tready[i] = 1'b1;
      end
      #3;
      for (int i = 0; i < 4; i++) begin
         chk("rst_tx_tready", 32'(tx_tready[i]), 1);
         chk("rst_rx_tvalid", 32'(rx_tvalid[i]), 0);
         chk("rst_rx_tdata", 32'(rx_tdata[i]), 0);
         chk("rst_busy", 32'(busy[i]), 0);
         chk("rst_miso", 32'(miso[i]), 0);
         chk("rst_flags", {30'd0, rx_overrun[i], tx_underrun[i]}, 0);
      end
      tick(3);
      rst_n = 1'b1;
      tick(4);

      for (int t = 0; t < 5; t++) begin
         for (int j = 0; j < tbl[t].ntx; j++) push_tx(tbl[t].k, tbl[t].tx[15-8*j -: 8]);
         tick(4);
         if (tbl[t].ntx > 0) chk("tx_tready_full", 32'(tx_tready[tbl[t].k]), 0);
         for (int j = 0; j < 4; j++) begin
            mw[j] = (j < 2) ? tbl[t].mo[15-8*j -: 8] : 8'h00;
            tm[j] = (j < 2) ? tbl[t].em[15-8*j -: 8] : 8'h00;
         end
         run_frame(tbl[t].k, tbl[t].nw, mw, 1'b1, tm, tbl[t].eu);
      end

      // consumer stalled across two words: first word held, second dropped
      rx_tready[0] = 1'b0;
      mw = '{8'h6B, 8'hD4, 8'h00, 8'h00};
      model_frame(0, 16, em, eu);
      r0 = rxq[0].size();
      o0 = ovr[0];
      xfer(0, 16, mw, 1'b1, got);
      tick(4);
      chk("ovr_rx_tvalid", 32'(rx_tvalid[0]), 1);
      chk("ovr_rx_tdata", 32'(rx_tdata[0]), 32'h6B);
      chk("ovr_pulses", 32'(ovr[0] - o0), 1);
      rx_tready[0] = 1'b1;
      tick(3);
      chk("ovr_drained", 32'(rx_tvalid[0]), 0);
      chk("ovr_rx_count", 32'(rxq[0].size() - r0), 1);
      if (rxq[0].size() > 0) chk("ovr_rx_word", 32'(rxq[0][rxq[0].size()-1]), 32'h6B);

      // deselect after three bits, then a full LSB-first word
      mw = '{8'hA6, 8'h00, 8'h00, 8'h00};
      model_frame(3, 3, em, eu);
      r0 = rxq[3].size();
      u0 = und[3];
      xfer(3, 3, mw, 1'b1, got);
      tick(4);
      chk("abort_rx_count", 32'(rxq[3].size() - r0), 0);
      chk("abort_underrun", 32'(und[3] - u0), 32'(eu));
      chk("abort_rx_tvalid", 32'(rx_tvalid[3]), 0);
      mw = '{8'h81, 8'h00, 8'h00, 8'h00};
      run_frame(3, 1, mw, 1'b0, tm, 0);

      for (int it = 0; it < 40; it++) begin
         k   = int'($urandom_range(0, 3));
         nw  = int'($urandom_range(1, 3));
         ntx = int'($urandom_range(0, nw + 1));
         for (int j = 0; j < ntx; j++) push_tx(k, 8'($urandom));
         tick(4);
         for (int j = 0; j < 4; j++) mw[j] = 8'($urandom);
         run_frame(k, nw, mw, 1'b0, tm, 0);
      end

      // async reset in the middle of a word with a word parked in the holding register
      push_tx(0, 8'h77);
      push_tx(0, 8'h99);
      tick(4);
      mw = '{8'hFF, 8'h00, 8'h00, 8'h00};
      model_frame(0, 4, em, eu);
      xfer(0, 4, mw, 1'b0, got);
      chk("pre_rst_busy", 32'(busy[0]), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_miso", 32'(miso[0]), 0);
      chk("midrst_tx_tready", 32'(tx_tready[0]), 1);
      chk("midrst_rx_tvalid", 32'(rx_tvalid[0]), 0);
      chk("midrst_rx_tdata", 32'(rx_tdata[0]), 0);
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         for (int j = fptr[i]; j < fq[i].size(); j++) mq[i].push_back(fq[i][j]);
      end
      tick(2);
      cs_n[0] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(6);
      chk("post_rst_busy", 32'(busy[0]), 0);
      mw = '{8'h5A, 8'h00, 8'h00, 8'h00};
      run_frame(0, 1, mw, 1'b0, tm, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
